// File: rtl/cnt_pkg.sv
// Shared encodings and default widths for the counter sequencer.
// The FSM state encoding is visible on the State debug port.
package cnt_pkg;

  localparam int CNT_W = 8;
  localparam int REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Repeat count loaded at Start: one-shot always runs exactly one period.
  function automatic logic [REP_W-1:0] start_reps(input logic mode, input logic [REP_W-1:0] reps);
    logic [REP_W-1:0] val;
    if (mode == MODE_PERIODIC) begin
      val = reps;
    end else begin
      val = {{(REP_W-1){1'b0}}, 1'b1};
    end
    return val;
  endfunction

endpackage

// File: rtl/cnt_seq_rep.sv
// Repeat down-counter: tracks periods remaining, including the one in progress.
// A zero load in periodic mode means "run forever" and freezes the count.
module cnt_seq_rep
  import cnt_pkg::*;
#(
  parameter int RW = REP_W
) (
  input  logic          Clk,
  input  logic          MR,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          load_inf,
  input  logic          dec,
  input  logic          clr,
  output logic [RW-1:0] rep_left,
  output logic          infinite,
  output logic          last
);

  logic [RW-1:0] cnt_r;
  logic          inf_r;

  // Count register: clear beats load beats decrement.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      cnt_r <= {RW{1'b0}};
      inf_r <= 1'b0;
    end else if (clr) begin
      cnt_r <= {RW{1'b0}};
      inf_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      inf_r <= load_inf;
    end else if (dec && !inf_r && (cnt_r != {RW{1'b0}})) begin
      cnt_r <= cnt_r - {{(RW-1){1'b0}}, 1'b1};
      inf_r <= inf_r;
    end else begin
      cnt_r <= cnt_r;
      inf_r <= inf_r;
    end
  end

  assign rep_left = cnt_r;
  assign infinite = inf_r;
  assign last     = (cnt_r == {{(RW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Interval-timer sequencer around an external cascaded QH/QL counter:
// clears/enables the counter, compares against a latched terminal value, emits Tick/Done.
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int W  = CNT_W,
  parameter int RW = REP_W
) (
  input  logic            Clk,
  input  logic            MR,
  input  logic            Start,
  input  logic            Stop,
  input  logic            Hold,
  input  logic            Mode,
  input  logic [W-1:0]    Term,
  input  logic [RW-1:0]   Reps,
  input  logic [W/2-1:0]  QH,
  input  logic [W/2-1:0]  QL,
  output logic            CntEn,
  output logic            CntClr,
  output logic            Busy,
  output logic            Tick,
  output logic            Done,
  output logic [RW-1:0]   RepLeft,
  output logic [1:0]      State
);

  seq_state_t    state_r;
  seq_state_t    state_nxt_s;
  logic [W-1:0]  term_r;
  logic          load_s;
  logic          tick_s;
  logic          rep_dec_s;
  logic          rep_clr_s;
  logic          rep_inf_s;
  logic          rep_last_s;
  logic          load_inf_s;
  logic [RW-1:0] load_val_s;
  logic          match_s;

  assign load_val_s = start_reps(Mode, Reps);
  assign load_inf_s = (Mode == MODE_PERIODIC) && (Reps == {RW{1'b0}});
  assign match_s    = ({QH, QL} == term_r) && !Hold;

  cnt_seq_rep #(
    .RW (RW)
  ) u_rep (
    .Clk      (Clk),
    .MR       (MR),
    .load     (load_s),
    .load_val (load_val_s),
    .load_inf (load_inf_s),
    .dec      (rep_dec_s),
    .clr      (rep_clr_s),
    .rep_left (RepLeft),
    .infinite (rep_inf_s),
    .last     (rep_last_s)
  );

  // State, latched terminal value and the registered Tick pulse.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state_r <= ST_IDLE;
      term_r  <= {W{1'b0}};
      Tick    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      Tick    <= tick_s;
      if (load_s) begin
        term_r <= Term;
      end else begin
        term_r <= term_r;
      end
    end
  end

  // Next state plus Mealy counter controls; Stop overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    tick_s      = 1'b0;
    rep_dec_s   = 1'b0;
    rep_clr_s   = 1'b0;
    CntEn       = 1'b0;
    CntClr      = 1'b0;
    Done        = 1'b0;
    if (Stop) begin
      state_nxt_s = ST_IDLE;
      rep_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            state_nxt_s = ST_LOAD;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          CntClr      = 1'b1;
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          CntEn = !Hold;
          if (match_s) begin
            tick_s = 1'b1;
            if (rep_last_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              // Wrap to 0 instead of Term+1 so every period is Term+1 cycles.
              CntClr      = 1'b1;
              rep_dec_s   = !rep_inf_s;
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          Done        = 1'b1;
          rep_clr_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  assign Busy  = (state_r == ST_LOAD) || (state_r == ST_RUN);
  assign State = state_r;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl with a behavioural cascaded counter (clear > enable > hold).
// Cycle c is the clock period following edge c-1, with Start sampled at edge 0.
module tb_cnt_seq_ctrl;
  import cnt_pkg::*;

  localparam int W  = CNT_W;
  localparam int RW = REP_W;

  logic          Clk = 1'b0;
  logic          MR = 1'b0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic          Hold = 1'b0;
  logic          Mode = 1'b0;
  logic [W-1:0]  Term = '0;
  logic [RW-1:0] Reps = '0;
  logic [W-1:0]  q_m;
  logic          CntEn, CntClr, Busy, Tick, Done;
  logic [RW-1:0] RepLeft;
  logic [1:0]    State;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge MR) begin
    if (!MR) q_m <= '0;
    else if (CntClr) q_m <= '0;
    else if (CntEn) q_m <= q_m + 8'd1;
  end

  cnt_seq_ctrl #(.W(W), .RW(RW)) dut (
    .Clk(Clk), .MR(MR), .Start(Start), .Stop(Stop), .Hold(Hold), .Mode(Mode),
    .Term(Term), .Reps(Reps), .QH(q_m[W-1:W/2]), .QL(q_m[W/2-1:0]),
    .CntEn(CntEn), .CntClr(CntClr), .Busy(Busy), .Tick(Tick), .Done(Done),
    .RepLeft(RepLeft), .State(State)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic sample;
    @(negedge Clk);
  endtask

  // Drives Start during cycle 0 so it is sampled at edge 0.
  task automatic start_seq(input logic [W-1:0] t, input logic m, input logic [RW-1:0] r);
    next_cycle;
    cyc = 0;
    Start = 1'b1; Stop = 1'b0; Hold = 1'b0;
    Term = t; Mode = m; Reps = r;
  endtask

  task automatic oneshot_term9(input string pfx);
    start_seq(8'd9, MODE_ONESHOT, 4'd7);
    for (int c = 1; c <= 13; c++) begin
      next_cycle;
      Start = 1'b0;
      sample;
      check_val({pfx, "_busy"}, 32'(Busy), 32'(c <= 11));
      check_val({pfx, "_clr"}, 32'(CntClr), 32'(c == 1));
      check_val({pfx, "_tick"}, 32'(Tick), 32'(c == 12));
      check_val({pfx, "_done"}, 32'(Done), 32'(c == 12));
      check_val({pfx, "_state"}, 32'(State),
                (c == 1) ? 32'd1 : (c <= 11) ? 32'd2 : (c == 12) ? 32'd3 : 32'd0);
      check_val({pfx, "_rep"}, 32'(RepLeft), (c <= 12) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // Reset state
    sample;
    check_val("rst_en", 32'(CntEn), 32'd0);
    check_val("rst_clr", 32'(CntClr), 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_tick", 32'(Tick), 32'd0);
    check_val("rst_done", 32'(Done), 32'd0);
    check_val("rst_rep", 32'(RepLeft), 32'd0);
    check_val("rst_state", 32'(State), 32'd0);
    next_cycle;
    MR = 1'b1;

    // One-shot, Term=9
    oneshot_term9("s1");

    // Periodic, Term=3, Reps=3
    start_seq(8'd3, MODE_PERIODIC, 4'd3);
    for (int c = 1; c <= 15; c++) begin
      next_cycle;
      Start = 1'b0;
      sample;
      check_val("s2_tick", 32'(Tick), 32'(c == 6 || c == 10 || c == 14));
      check_val("s2_done", 32'(Done), 32'(c == 14));
      check_val("s2_clr", 32'(CntClr), 32'(c == 1 || c == 5 || c == 9));
      check_val("s2_busy", 32'(Busy), 32'(c <= 13));
      check_val("s2_rep", 32'(RepLeft),
                (c <= 5) ? 32'd3 : (c <= 9) ? 32'd2 : (c <= 14) ? 32'd1 : 32'd0);
    end

    // Periodic infinite, Term=0, Stop in cycle 20
    start_seq(8'd0, MODE_PERIODIC, 4'd0);
    for (int c = 1; c <= 25; c++) begin
      next_cycle;
      Start = 1'b0;
      Stop = (c == 20);
      sample;
      check_val("s3_tick", 32'(Tick), 32'(c >= 3 && c <= 20));
      check_val("s3_done", 32'(Done), 32'd0);
      check_val("s3_state", 32'(State), (c == 1) ? 32'd1 : (c <= 20) ? 32'd2 : 32'd0);
      check_val("s3_en", 32'(CntEn), 32'(c >= 2 && c <= 19));
      check_val("s3_rep", 32'(RepLeft), 32'd0);
    end
    Stop = 1'b0;

    // One-shot Term=5 with Hold in cycles 4-6
    start_seq(8'd5, MODE_ONESHOT, 4'd0);
    for (int c = 1; c <= 13; c++) begin
      next_cycle;
      Start = 1'b0;
      Hold = (c >= 4 && c <= 6);
      sample;
      check_val("s4_en", 32'(CntEn), 32'((c >= 2 && c <= 3) || (c >= 7 && c <= 10)));
      check_val("s4_tick", 32'(Tick), 32'(c == 11));
      check_val("s4_done", 32'(Done), 32'(c == 11));
      check_val("s4_state", 32'(State),
                (c == 1) ? 32'd1 : (c <= 10) ? 32'd2 : (c == 11) ? 32'd3 : 32'd0);
    end
    Hold = 1'b0;

    // One-shot Term=7 with Start and Term=1 driven mid-RUN
    start_seq(8'd7, MODE_ONESHOT, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      next_cycle;
      Start = (c >= 3 && c <= 5);
      if (c == 3) Term = 8'd1;
      sample;
      check_val("s5_tick", 32'(Tick), 32'(c == 10));
      check_val("s5_done", 32'(Done), 32'(c == 10));
      check_val("s5_busy", 32'(Busy), 32'(c <= 9));
    end

    // Periodic Term=2, Reps=3, MR low in cycle 5
    start_seq(8'd2, MODE_PERIODIC, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      next_cycle;
      Start = 1'b0;
      sample;
      check_val("s6_clr", 32'(CntClr), 32'(c == 1 || c == 4));
      check_val("s6_rep", 32'(RepLeft), 32'd3);
    end
    next_cycle;
    MR = 1'b0;
    sample;
    check_val("s6_mr_en", 32'(CntEn), 32'd0);
    check_val("s6_mr_clr", 32'(CntClr), 32'd0);
    check_val("s6_mr_busy", 32'(Busy), 32'd0);
    check_val("s6_mr_tick", 32'(Tick), 32'd0);
    check_val("s6_mr_done", 32'(Done), 32'd0);
    check_val("s6_mr_rep", 32'(RepLeft), 32'd0);
    check_val("s6_mr_state", 32'(State), 32'd0);
    next_cycle;
    MR = 1'b1;
    oneshot_term9("s6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
Sequencer that drives the team's 8-bit cascaded counter (cnt256-style QH/QL nibble pair) as a programmable interval timer. It clears and enables the counter, compares the counter value against a latched terminal value, and emits one Tick per period for a programmed number of periods (or forever). Sits between a host/control FSM and the counter, which gains synchronous clear (priority) and enable inputs driven from here.

Parameters:
W, 8, counter width; QH and QL are each W/2 bits
RW, 4, width of repeat count and RepLeft

Ports:
Clk  in  1  system clock, rising edge
MR  in  1  master reset, asynchronous, active-low
Start  in  1  begin sequence; sampled only in IDLE
Stop  in  1  abort to IDLE; highest priority after MR
Hold  in  1  freeze counting while in RUN
Mode  in  1  0 = one-shot (single period), 1 = periodic
Term  in  W  terminal count; period = Term+1 cycles
Reps  in  RW  number of periods in periodic mode; 0 = infinite
QH  in  W/2  counter high nibble
QL  in  W/2  counter low nibble
CntEn  out  1  counter enable
CntClr  out  1  counter synchronous clear (overrides CntEn)
Busy  out  1  high in LOAD or RUN
Tick  out  1  one-cycle pulse per completed period, registered
Done  out  1  one-cycle pulse on sequence completion
RepLeft  out  RW  periods remaining, including the current one
State  out  2  current state, for debug

Behaviour:
- Reset (MR=0, async): state IDLE, TermR=0, RepLeft=0, Tick=0. Combinational outputs then give CntEn=0, CntClr=0, Busy=0, Done=0.
- States: IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE: Start=1 & Stop=0 -> LOAD. Same edge: TermR<=Term. RepLeft<=1 if Mode=0 (Reps ignored), else Reps.
- LOAD: CntClr=1, CntEn=0. Next state RUN, so the counter reads 0 in the first RUN cycle.
- RUN: CntEn = ~Hold. match = ({QH,QL}==TermR) & ~Hold.
  - On match, Tick<=1 next cycle.
  - If last = (RepLeft==1): next state DONE, CntClr=0.
  - Otherwise: CntClr=1 (Mealy, same cycle), so the counter goes to 0 instead of Term+1. RepLeft decrements unless infinite (periodic with RepLeft==0).
- DONE: Done=1, CntEn=0, RepLeft<=0. Next state IDLE unconditionally.
- Hold: counter frozen and match suppressed. State and RepLeft unchanged.
- Stop=1 in any state: next state IDLE, RepLeft<=0, no Tick/Done generated from that cycle. CntEn is driven 0 combinationally in the Stop cycle.
- Start outside IDLE is ignored. Term/Mode/Reps changes after Start have no effect until the next Start.
- Term=0: match every RUN cycle, so Tick fires every cycle. Term=2^W-1: full 256-cycle period; the counter carry is not used.
- Stop and match in the same cycle: Stop wins (no Tick).
- MR mid-run: immediate IDLE, all outputs at reset values.
- Timing, with Start sampled at edge 0:
  - Cycle 1 is LOAD; first RUN cycle is cycle 2, with Q=0.
  - Match k (k=1..N) occurs in cycle 1+k*(Term+1).
  - Tick k is high in cycle 2+k*(Term+1).
  - Done coincides with the final Tick.

Decomposition:
- Package cnt_pkg:
  - state encodings ST_IDLE..ST_DONE
  - MODE_ONESHOT / MODE_PERIODIC constants
  - default widths W=8, RW=4
- One natural sub-module: cnt_seq_rep, the RW-bit repeat down-counter with load, decrement, infinite flag and "last" output.
- Comparator and FSM stay in cnt_seq_ctrl.
- The bench provides a behavioural counter model (clear > enable > hold).

Test Plan:
- One-shot, Term=9, Start at edge 0: Busy cycles 1-11; CntClr only in cycle 1; Tick and Done both high in cycle 12 only; State returns to IDLE in cycle 13.
- Periodic, Term=3, Reps=3: Ticks in cycles 6, 10, 14; Done in cycle 14. RepLeft reads 3, 2, 1 after each match; CntClr high in cycles 5 and 9.
- Periodic, Reps=0, Term=0: Tick every cycle from cycle 3 onward. Stop in cycle 20 gives IDLE in cycle 21, no further Tick, Done never asserted.
- Hold in cycles 4-6 during one-shot Term=5: counter freezes at 2, CntEn=0 for those cycles; Tick and Done slip 3 cycles, from 8 to 11.
- Start re-asserted and Term changed to 1 mid-RUN (Term=7): both ignored; Tick still at cycle 10.
- MR low in cycle 5 of a periodic run: CntEn, CntClr, Busy, Tick, Done and RepLeft all 0 immediately. After MR release, a new Start behaves as in scenario 1.
